// File: rtl/fb_scanout_vga_pkg.sv
// Shared VGA timing defaults and control-bundle type for the framebuffer scanout path.
package fb_scanout_vga_pkg;

    localparam int unsigned CNT_W = 10;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    // Region flags are carried as "asserted" bits; pin polarity is applied at the output only.
    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
        logic fs;
    } vga_ctrl_t;

    function automatic logic sync_level(input logic asserted, input bit pol);
        return asserted ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Free-running VGA h/v counters with raw active, sync and frame-start decode.
module vga_timing_gen
    import fb_scanout_vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic [CNT_W-1:0] h_cnt_o,
    output logic [CNT_W-1:0] v_cnt_o,
    output vga_ctrl_t        ctrl_o
);
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;

    always_comb begin
        h_cnt_d = h_cnt_q + CNT_W'(1);
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == CNT_W'(H_TOTAL - 1)) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == CNT_W'(V_TOTAL - 1)) ? '0 : v_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    always_comb begin
        ctrl_o.de = (h_cnt_q < CNT_W'(H_ACTIVE)) && (v_cnt_q < CNT_W'(V_ACTIVE));
        ctrl_o.hs = (h_cnt_q >= CNT_W'(HS_START)) && (h_cnt_q < CNT_W'(HS_END));
        ctrl_o.vs = (v_cnt_q >= CNT_W'(VS_START)) && (v_cnt_q < CNT_W'(VS_END));
        ctrl_o.fs = (h_cnt_q == '0) && (v_cnt_q == '0);
    end

    assign h_cnt_o = h_cnt_q;
    assign v_cnt_o = v_cnt_q;

endmodule

// File: rtl/fb_scanout_vga.sv
// Scans a half-resolution RGB444 framebuffer out to VGA pins with 2x nearest-neighbour
// upscaling; all pin outputs trail the counters by exactly 3 cycles.
module fb_scanout_vga
    import fb_scanout_vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter int unsigned FB_W     = 320,
    parameter int unsigned FB_H     = 240,
    parameter int unsigned AW       = 17,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    output logic [AW-1:0] fb_addr,
    input  logic [11:0]   fb_data,
    output logic [3:0]    vga_r,
    output logic [3:0]    vga_g,
    output logic [3:0]    vga_b,
    output logic          vga_hs,
    output logic          vga_vs,
    output logic          vga_de,
    output logic          frame_start
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if ((FB_W * 2 != H_ACTIVE) || (FB_H * 2 != V_ACTIVE)) begin : g_bad_geometry
        $error("framebuffer must be exactly half the active area in each dimension");
    end

    logic [CNT_W-1:0] h_cnt, v_cnt;
    vga_ctrl_t        ctrl_raw, ctrl_q1, ctrl_q2, ctrl_q3;
    logic [AW-1:0]    row_base_q, row_base_d;
    logic [AW-1:0]    fb_addr_q, fb_addr_d;
    logic [11:0]      rgb_q, rgb_d;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk_i   (clk),
        .rst_i   (rst),
        .h_cnt_o (h_cnt),
        .v_cnt_o (v_cnt),
        .ctrl_o  (ctrl_raw)
    );

    // Advance one source row after every odd active line, so each row is shown twice.
    always_comb begin
        row_base_d = row_base_q;
        if (h_cnt == CNT_W'(H_TOTAL - 1)) begin
            if (v_cnt == CNT_W'(V_TOTAL - 1)) begin
                row_base_d = '0;
            end else if (v_cnt[0] && (v_cnt < CNT_W'(V_ACTIVE - 1))) begin
                row_base_d = row_base_q + AW'(FB_W);
            end
        end
    end

    // Freezing the address in blanking keeps it inside the buffer.
    assign fb_addr_d = ctrl_raw.de ? row_base_q + AW'(h_cnt[CNT_W-1:1]) : fb_addr_q;
    assign rgb_d     = ctrl_q2.de ? fb_data : 12'h000;

    always_ff @(posedge clk) begin
        if (rst) begin
            row_base_q <= '0;
            fb_addr_q  <= '0;
            ctrl_q1    <= '0;
            ctrl_q2    <= '0;
            ctrl_q3    <= '0;
            rgb_q      <= '0;
        end else begin
            row_base_q <= row_base_d;
            fb_addr_q  <= fb_addr_d;
            ctrl_q1    <= ctrl_raw;
            ctrl_q2    <= ctrl_q1;
            ctrl_q3    <= ctrl_q2;
            rgb_q      <= rgb_d;
        end
    end

    assign fb_addr     = fb_addr_q;
    assign vga_r       = rgb_q[11:8];
    assign vga_g       = rgb_q[7:4];
    assign vga_b       = rgb_q[3:0];
    assign vga_de      = ctrl_q3.de;
    assign frame_start = ctrl_q3.fs;
    assign vga_hs      = sync_level(ctrl_q3.hs, SYNC_POL);
    assign vga_vs      = sync_level(ctrl_q3.vs, SYNC_POL);

endmodule
